// File: rtl/key_event_tx_if.sv
// Byte handshake between key_event_tx (master) and a UART byte sender (slave).
interface key_event_tx_if;
  logic [7:0] tx_data;
  logic       tx_send;
  logic       tx_done;

  modport master (output tx_data, output tx_send, input tx_done);
  modport slave  (input tx_data, input tx_send, output tx_done);
endinterface

// File: rtl/key_event_tx.sv
// Debounces a bank of key lines, scans them round-robin, queues press/release bytes
// and hands them to a UART sender. Define KEY_RELEASE_EVT_EN to also emit release events.
module key_event_tx #(
  parameter int N_KEYS        = 40,
  parameter int STABLE_CYCLES = 16,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_KEYS-1:0]           key_down,
  key_event_tx_if.master              tx,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        ovf
);

  localparam int               PTR_W    = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;
  localparam int               AW       = $clog2(FIFO_DEPTH);
  localparam int               LW       = AW + 1;
  localparam logic [PTR_W-1:0] LAST_KEY = PTR_W'(N_KEYS - 1);
  localparam logic [7:0]       CNT_MAX  = 8'(STABLE_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [N_KEYS-1:0] r_raw_q;
  logic [N_KEYS-1:0] r_stable;
  logic [N_KEYS-1:0] r_reported;
  logic [7:0]        r_cnt [N_KEYS];
  logic [PTR_W-1:0]  r_ptr;
  logic [7:0]        r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_level;
  logic              r_ovf;
  logic [1:0]        r_state;
  logic [7:0]        r_tx_data;
  logic              r_tx_send;

  logic       w_changed;
  logic       w_full;
  logic       w_empty;
  logic       w_push;
  logic       w_pop;
  logic       w_defer;
  logic       w_update;
  logic [6:0] w_key_idx;
  logic [7:0] w_event;

  // A counter only runs while the registered raw level disagrees with the debounced one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_raw_q  <= '0;
      r_stable <= '0;
      for (int i = 0; i < N_KEYS; i++) r_cnt[i] <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
      r_raw_q <= key_down;
      for (int i = 0; i < N_KEYS; i++) begin
        if (r_raw_q[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          r_stable[i] <= r_raw_q[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 8'd1;
        end
      end
    end
  end

  assign w_changed = r_stable[r_ptr] != r_reported[r_ptr];
  assign w_full    = r_level == LW'(FIFO_DEPTH);
  assign w_empty   = r_level == '0;
  assign w_pop     = (r_state == S_IDLE) && !w_empty;
  assign w_key_idx = 7'(r_ptr);
  assign w_event   = {r_stable[r_ptr], w_key_idx};

  always_comb begin
    // NOTE: defaults first, so no path leaves a signal unassigned and infers a latch.
    w_push   = 1'b0;
    w_defer  = 1'b0;
    w_update = 1'b0;
    if (w_changed) begin
`ifdef KEY_RELEASE_EVT_EN
      if (w_full) begin
        w_defer = 1'b1;
      end else begin
        w_push   = 1'b1;
        w_update = 1'b1;
      end
`else
      if (!r_stable[r_ptr]) begin
        w_update = 1'b1;
      end else if (w_full) begin
        w_defer = 1'b1;
      end else begin
        w_push   = 1'b1;
        w_update = 1'b1;
      end
`endif
    end
  end

  // A deferred event keeps reported != stable, so the next pass retries it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr      <= '0;
      r_reported <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_ptr <= (r_ptr == LAST_KEY) ? '0 : r_ptr + PTR_W'(1);
      if (w_update) r_reported[r_ptr] <= r_stable[r_ptr];
      if (w_defer)  r_ovf <= 1'b1;
    end
  end

  // NOTE: storage is not reset; the pointers and level alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_event;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_tx_data <= 8'h00;
      r_tx_send <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_tx_data <= r_mem[r_rd_ptr];
            r_tx_send <= 1'b1;
            r_state   <= S_SEND;
          end
        end
        S_SEND: begin
          r_tx_send <= 1'b0;
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          if (tx.tx_done) r_state <= S_IDLE;
        end
        default: begin
          r_tx_send <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign tx.tx_data = r_tx_data;
  assign tx.tx_send = r_tx_send;
  assign fifo_level = r_level;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_key_event_tx.sv
// Directed bench for key_event_tx (N_KEYS=40, STABLE_CYCLES=16, FIFO_DEPTH=8).
// Release-event expectations follow KEY_RELEASE_EVT_EN when the bench is built with it.
module tb_key_event_tx;

  logic        clk;
  logic        rst;
  logic [39:0] key_down;
  logic [3:0]  fifo_level;
  logic        ovf;

  key_event_tx_if tx ();

  key_event_tx #(
    .N_KEYS        (40),
    .STABLE_CYCLES (16),
    .FIFO_DEPTH    (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_down   (key_down),
    .tx         (tx),
    .fifo_level (fifo_level),
    .ovf        (ovf)
  );

  int          total;
  int          bad;
  logic [7:0]  sent_q [$];
  bit          done_en;
  bit          outstanding;
  int          pending;
  int          hold_err;
  logic [7:0]  last_byte;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // UART sender model: logs every strobe, answers tx_done 10 cycles later when enabled.
  initial begin
    tx.tx_done  = 1'b0;
    outstanding = 1'b0;
    pending     = 0;
    hold_err    = 0;
    last_byte   = 8'h00;
    forever begin
      @(negedge clk);
      tx.tx_done = 1'b0;
      if (rst) begin
        outstanding = 1'b0;
        pending     = 0;
      end else begin
        if (outstanding) begin
          if (tx.tx_data !== last_byte) hold_err++;
          if (pending > 0) pending--;
          if (pending == 0 && done_en) begin
            tx.tx_done  = 1'b1;
            outstanding = 1'b0;
          end
        end
        if (tx.tx_send === 1'b1) begin
          sent_q.push_back(tx.tx_data);
          last_byte   = tx.tx_data;
          outstanding = 1'b1;
          pending     = 10;
        end
      end
    end
  end

  // Leaves the bench at the negedge where rst drops; the next posedge is the first live edge.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sent_q.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if (tx.tx_send !== 1'b0) begin bad++; $display("FAIL reset_tx_send: got %b want 0", tx.tx_send); end
    total++;
    if (tx.tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data: got %h want 00", tx.tx_data); end
    total++;
    if (fifo_level !== 4'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    total++;
    if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", ovf); end
  endtask

  // Key 5 pressed 25 cycles after reset: it debounces while ptr is at 2, so it is queued at once.
  task automatic test_press_release();
    int first_i;
    int exp_n;
    first_i = 0;
`ifdef KEY_RELEASE_EVT_EN
    exp_n = 2;
`else
    exp_n = 1;
`endif
    key_down = '0;
    do_reset();
    repeat (25) @(negedge clk);
    key_down[5] = 1'b1;
    for (int i = 1; i <= 220; i++) begin
      @(negedge clk);
      if (i == 20) key_down[5] = 1'b0;
      if (tx.tx_send === 1'b1 && first_i == 0) first_i = i;
    end
    total++;
    if (first_i == 0 || first_i > 60) begin
      bad++; $display("FAIL press_latency: got %0d cycles want 1..60", first_i);
    end
    total++;
    if (sent_q.size() != exp_n) begin
      bad++; $display("FAIL press_release_count: got %0d want %0d", sent_q.size(), exp_n);
    end
    total++;
    if (sent_q.size() < 1 || sent_q[0] !== 8'h85) begin
      bad++; $display("FAIL press_byte: got %h want 85", (sent_q.size() > 0) ? sent_q[0] : 8'hxx);
    end
`ifdef KEY_RELEASE_EVT_EN
    total++;
    if (sent_q.size() < 2 || sent_q[1] !== 8'h05) begin
      bad++; $display("FAIL release_byte: got %h want 05", (sent_q.size() > 1) ? sent_q[1] : 8'hxx);
    end
`endif
    total++;
    if (hold_err != 0) begin bad++; $display("FAIL data_hold: got %0d changes want 0", hold_err); end
    total++;
    if (fifo_level !== 4'd0) begin bad++; $display("FAIL press_level_end: got %0d want 0", fifo_level); end
  endtask

  task automatic test_glitch();
    int max_level;
    int sends;
    max_level = 0;
    sends     = 0;
    key_down  = '0;
    do_reset();
    repeat (5) @(negedge clk);
    key_down[3] = 1'b1;
    for (int i = 1; i <= 120; i++) begin
      @(negedge clk);
      if (i == 10) key_down[3] = 1'b0;
      if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
      if (tx.tx_send === 1'b1) sends++;
    end
    total++;
    if (sends != 0) begin bad++; $display("FAIL glitch_sends: got %0d want 0", sends); end
    total++;
    if (max_level != 0) begin bad++; $display("FAIL glitch_level: got %0d want 0", max_level); end
  endtask

  // Keys rise 23 cycles after reset so they debounce exactly as ptr wraps to 0: order 0,1,39.
  task automatic test_simultaneous();
    key_down = '0;
    do_reset();
    repeat (23) @(negedge clk);
    key_down[0]  = 1'b1;
    key_down[1]  = 1'b1;
    key_down[39] = 1'b1;
    repeat (200) @(negedge clk);
    total++;
    if (sent_q.size() != 3) begin bad++; $display("FAIL simul_count: got %0d want 3", sent_q.size()); end
    total++;
    if (sent_q.size() < 1 || sent_q[0] !== 8'h80) begin
      bad++; $display("FAIL simul_byte0: got %h want 80", (sent_q.size() > 0) ? sent_q[0] : 8'hxx);
    end
    total++;
    if (sent_q.size() < 2 || sent_q[1] !== 8'h81) begin
      bad++; $display("FAIL simul_byte1: got %h want 81", (sent_q.size() > 1) ? sent_q[1] : 8'hxx);
    end
    total++;
    if (sent_q.size() < 3 || sent_q[2] !== 8'hA7) begin
      bad++; $display("FAIL simul_byte2: got %h want a7", (sent_q.size() > 2) ? sent_q[2] : 8'hxx);
    end
  endtask

  // One byte goes out and stalls in WAIT; nine fill the queue to 8, the tenth is deferred.
  task automatic test_overflow();
    key_down = '0;
    done_en  = 1'b0;
    do_reset();
    key_down[19:10] = '1;
    repeat (100) @(negedge clk);
    total++;
    if (fifo_level !== 4'd8) begin bad++; $display("FAIL ovf_level_full: got %0d want 8", fifo_level); end
    total++;
    if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", ovf); end
    total++;
    if (sent_q.size() != 1) begin bad++; $display("FAIL ovf_stalled_sends: got %0d want 1", sent_q.size()); end
    done_en = 1'b1;
    repeat (500) @(negedge clk);
    total++;
    if (sent_q.size() != 10) begin bad++; $display("FAIL ovf_total_sends: got %0d want 10", sent_q.size()); end
    for (int k = 10; k < 20; k++) begin
      logic [7:0] exp_b;
      int         hits;
      exp_b = 8'h80 | 8'(k);
      hits  = 0;
      foreach (sent_q[j]) if (sent_q[j] === exp_b) hits++;
      total++;
      if (hits != 1) begin bad++; $display("FAIL ovf_byte_%h: got %0d copies want 1", exp_b, hits); end
    end
    total++;
    if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
    total++;
    if (fifo_level !== 4'd0) begin bad++; $display("FAIL ovf_level_drained: got %0d want 0", fifo_level); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    seen     = 1'b0;
    key_down = '0;
    do_reset();
    repeat (25) @(negedge clk);
    key_down[6] = 1'b1;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (tx.tx_send === 1'b1) seen = 1'b1;
    end
    total++;
    if (!seen) begin bad++; $display("FAIL mid_first_send: got none want tx_send within 100 cycles"); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (tx.tx_send !== 1'b0) begin bad++; $display("FAIL mid_tx_send: got %b want 0", tx.tx_send); end
    total++;
    if (tx.tx_data !== 8'h00) begin bad++; $display("FAIL mid_tx_data: got %h want 00", tx.tx_data); end
    total++;
    if (fifo_level !== 4'd0) begin bad++; $display("FAIL mid_level: got %0d want 0", fifo_level); end
    total++;
    if (ovf !== 1'b0) begin bad++; $display("FAIL mid_ovf: got %b want 0", ovf); end
    rst = 1'b0;
    sent_q.delete();
    repeat (150) @(negedge clk);
    total++;
    if (sent_q.size() != 1) begin bad++; $display("FAIL mid_resend_count: got %0d want 1", sent_q.size()); end
    total++;
    if (sent_q.size() < 1 || sent_q[0] !== 8'h86) begin
      bad++; $display("FAIL mid_resend_byte: got %h want 86", (sent_q.size() > 0) ? sent_q[0] : 8'hxx);
    end
  endtask

`ifndef KEY_RELEASE_EVT_EN
  task automatic test_release_disabled();
    key_down = '0;
    do_reset();
    repeat (25) @(negedge clk);
    key_down[7] = 1'b1;
    repeat (20) @(negedge clk);
    key_down[7] = 1'b0;
    repeat (200) @(negedge clk);
    total++;
    if (sent_q.size() != 1) begin bad++; $display("FAIL norel_count: got %0d want 1", sent_q.size()); end
    total++;
    if (sent_q.size() < 1 || sent_q[0] !== 8'h87) begin
      bad++; $display("FAIL norel_byte: got %h want 87", (sent_q.size() > 0) ? sent_q[0] : 8'hxx);
    end
    total++;
    if (ovf !== 1'b0) begin bad++; $display("FAIL norel_ovf: got %b want 0", ovf); end
  endtask
`endif

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    key_down = '0;
    done_en  = 1'b1;
    test_reset();
    test_press_release();
    test_glitch();
    test_simultaneous();
    test_overflow();
    test_reset_mid();
`ifndef KEY_RELEASE_EVT_EN
    test_release_disabled();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
